// File: rtl/fab_node.sv
// -----------------------------------------------------------------------------
// fab_node : one stop on the unidirectional ring fabric.
//
// Each cycle the stop either sinks the arriving slot into its local drop
// register (packet addressed here and drop register free), deflects it
// downstream with an incremented age (addressed here but drop register busy),
// or forwards it untouched.  A slot left empty is filled from the local add
// FIFO.  Ring traffic always wins over injection, so the ring never stalls.
//
// Ports
//   clk, reset_n             clock (rising edge), async active-low reset
//   fabric_in_*              upstream ring slot
//   fabric_out_*             downstream ring slot, registered (1-cycle hop)
//   fabric_add_valid/ready   local add request / add FIFO not full
//   fabric_add_*             add payload (src is implied: MY_NID)
//   fabric_drop_valid/ready  drop register occupied / local consumer accepts
//   fabric_drop_*            drop payload
//   fabric_add_count         registered add FIFO occupancy
//   fabric_defl_count        saturating count of deflected packets
// -----------------------------------------------------------------------------
module fab_node #(
  parameter int unsigned NID_W     = 4,
  parameter int unsigned TYPE_W    = 2,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned DATA_W    = 12,
  parameter int unsigned AGE_W     = 3,
  parameter int unsigned MY_NID    = 0,
  parameter int unsigned ADD_DEPTH = 4,
  parameter int unsigned DEFL_W    = 16
) (
  input  logic                           clk,
  input  logic                           reset_n,

  input  logic                           fabric_in_valid,
  input  logic [AGE_W-1:0]               fabric_in_age,
  input  logic [TYPE_W-1:0]              fabric_in_type,
  input  logic [NID_W-1:0]               fabric_in_src_nid,
  input  logic [NID_W-1:0]               fabric_in_dst_nid,
  input  logic [ADDR_W-1:0]              fabric_in_addr,
  input  logic [DATA_W-1:0]              fabric_in_data,

  output logic                           fabric_out_valid,
  output logic [AGE_W-1:0]               fabric_out_age,
  output logic [TYPE_W-1:0]              fabric_out_type,
  output logic [NID_W-1:0]               fabric_out_src_nid,
  output logic [NID_W-1:0]               fabric_out_dst_nid,
  output logic [ADDR_W-1:0]              fabric_out_addr,
  output logic [DATA_W-1:0]              fabric_out_data,

  input  logic                           fabric_add_valid,
  output logic                           fabric_add_ready,
  input  logic [TYPE_W-1:0]              fabric_add_type,
  input  logic [NID_W-1:0]               fabric_add_dst_nid,
  input  logic [ADDR_W-1:0]              fabric_add_addr,
  input  logic [DATA_W-1:0]              fabric_add_data,

  output logic                           fabric_drop_valid,
  input  logic                           fabric_drop_ready,
  output logic [TYPE_W-1:0]              fabric_drop_type,
  output logic [NID_W-1:0]               fabric_drop_src_nid,
  output logic [ADDR_W-1:0]              fabric_drop_addr,
  output logic [DATA_W-1:0]              fabric_drop_data,

  output logic [$clog2(ADD_DEPTH):0]     fabric_add_count,
  output logic [DEFL_W-1:0]              fabric_defl_count
);

  localparam int unsigned PTR_W = $clog2(ADD_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [NID_W-1:0] MY_ID   = NID_W'(MY_NID);
  localparam logic [CNT_W-1:0] FULL_CT = CNT_W'(ADD_DEPTH);

  typedef struct packed {
    logic              valid;
    logic [AGE_W-1:0]  age;
    logic [TYPE_W-1:0] ptype;
    logic [NID_W-1:0]  src;
    logic [NID_W-1:0]  dst;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } slot_t;

  typedef struct packed {
    logic              valid;
    logic [TYPE_W-1:0] ptype;
    logic [NID_W-1:0]  src;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } drop_t;

  typedef struct packed {
    logic [TYPE_W-1:0] ptype;
    logic [NID_W-1:0]  dst;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } add_t;

  slot_t             out_q,    out_d;
  drop_t             drop_q,   drop_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic [DEFL_W-1:0] defl_q,   defl_d;
  add_t              mem_q [ADD_DEPTH];

  logic drop_free, is_mine, do_drop, do_defl, push, pop;
  add_t add_in, head;

  // Slot decisions.  drop_free looks at this cycle's drop_ready so a
  // consume and a new load can happen on the same edge.
  assign drop_free = !drop_q.valid || fabric_drop_ready;
  assign is_mine   = fabric_in_valid && (fabric_in_dst_nid == MY_ID);
  assign do_drop   = is_mine && drop_free;
  assign do_defl   = is_mine && !drop_free;

  // Ready depends only on registered occupancy: a pop this cycle frees
  // space that becomes visible next cycle.
  assign fabric_add_ready = (count_q != FULL_CT);
  assign push = fabric_add_valid && fabric_add_ready;
  assign pop  = (!fabric_in_valid || do_drop) && (count_q != '0);

  assign add_in = '{ptype: fabric_add_type, dst: fabric_add_dst_nid,
                    addr: fabric_add_addr, data: fabric_add_data};
  assign head   = mem_q[rd_ptr_q];

  // Downstream slot: forward (possibly deflected) ring traffic, else inject.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    out_d = '0;
    if (fabric_in_valid && !do_drop) begin
      out_d.valid = 1'b1;
      out_d.age   = fabric_in_age;
      out_d.ptype = fabric_in_type;
      out_d.src   = fabric_in_src_nid;
      out_d.dst   = fabric_in_dst_nid;
      out_d.addr  = fabric_in_addr;
      out_d.data  = fabric_in_data;
      // Deflection ages the packet; age saturates instead of wrapping.
      if (do_defl && (fabric_in_age != '1)) begin
        out_d.age = fabric_in_age + AGE_W'(1);
      end
    end else if (pop) begin
      out_d.valid = 1'b1;
      out_d.age   = '0;
      out_d.ptype = head.ptype;
      out_d.src   = MY_ID;
      out_d.dst   = head.dst;
      out_d.addr  = head.addr;
      out_d.data  = head.data;
    end
  end

  // Drop register: load wins over consume; payload holds while stalled.
  always_comb begin
    drop_d = drop_q;
    if (do_drop) begin
      drop_d.valid = 1'b1;
      drop_d.ptype = fabric_in_type;
      drop_d.src   = fabric_in_src_nid;
      drop_d.addr  = fabric_in_addr;
      drop_d.data  = fabric_in_data;
    end else if (drop_q.valid && fabric_drop_ready) begin
      drop_d.valid = 1'b0;
    end
  end

  // FIFO pointers wrap naturally since ADD_DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    defl_d   = defl_q;
    if (do_defl && (defl_q != '1)) begin
      defl_d = defl_q + DEFL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q    <= '0;
      drop_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      defl_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      out_q    <= out_d;
      drop_q   <= drop_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      defl_q   <= defl_d;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; entries are only read
  // when count_q says they were written, so emptying the pointers suffices.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= add_in;
    end
  end

  assign fabric_out_valid    = out_q.valid;
  assign fabric_out_age      = out_q.age;
  assign fabric_out_type     = out_q.ptype;
  assign fabric_out_src_nid  = out_q.src;
  assign fabric_out_dst_nid  = out_q.dst;
  assign fabric_out_addr     = out_q.addr;
  assign fabric_out_data     = out_q.data;

  assign fabric_drop_valid   = drop_q.valid;
  assign fabric_drop_type    = drop_q.ptype;
  assign fabric_drop_src_nid = drop_q.src;
  assign fabric_drop_addr    = drop_q.addr;
  assign fabric_drop_data    = drop_q.data;

  assign fabric_add_count    = count_q;
  assign fabric_defl_count   = defl_q;

endmodule
